// File: rtl/data_memory.sv
// Byte-addressed little-endian data memory with 32-bit word access.
// Word access wraps modulo DEPTH, reads are combinational, writes land on the rising clock edge.
module data_memory #(
   parameter int unsigned DEPTH = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic [31:0] writeData,
   input  logic        memRead,
   input  logic        memWrite,
   output logic [31:0] memData
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [7:0]    data [0:DEPTH-1];

   logic [AW-1:0] idx0_c;
   logic [AW-1:0] idx1_c;
   logic [AW-1:0] idx2_c;
   logic [AW-1:0] idx3_c;
   logic          addr_unused_c;

   // Byte lane indices; the AW-bit adds wrap naturally at the top of memory.
   always_comb begin
      idx0_c = address[AW-1:0];
      idx1_c = idx0_c + AW'(1);
      idx2_c = idx0_c + AW'(2);
      idx3_c = idx0_c + AW'(3);
   end

   // Upper address bits are ignored by design.
   assign addr_unused_c = ^address[31:AW];

   // Full-word store; reset clears the whole array immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            data[i] <= 8'h00;
         end
      end else if (memWrite) begin
         data[idx0_c] <= writeData[7:0];
         data[idx1_c] <= writeData[15:8];
         data[idx2_c] <= writeData[23:16];
         data[idx3_c] <= writeData[31:24];
      end
   end

   // Zero-latency load, forced to zero while idle or held in reset.
   always_comb begin
      memData = 32'h0;
      if (reset && memRead) begin
         memData = {data[idx3_c], data[idx2_c], data[idx1_c], data[idx0_c]};
      end
   end

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: stimulus queues expectations, a monitor
// samples the DUT on a sample strobe and compares.
module tb_data_memory;

   localparam int unsigned DEPTH = 256;

   logic        clk;
   logic        reset;
   logic [31:0] address;
   logic [31:0] writeData;
   logic        memRead;
   logic        memWrite;
   logic [31:0] memData;

   typedef struct {
      int          kind;   // 0: memData, 1: data[idx]
      int          idx;
      logic [31:0] exp;
      string       name;
   } exp_t;

   exp_t q[$];
   event chk_ev;
   int   total = 0;
   int   bad   = 0;

   data_memory #(.DEPTH(DEPTH)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .address   (address),
      .writeData (writeData),
      .memRead   (memRead),
      .memWrite  (memWrite),
      .memData   (memData)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Monitor: on each strobe, wait 1 time unit and check every queued expectation.
   initial begin
      forever begin
         @(chk_ev);
         #1;
         while (q.size() > 0) begin
            exp_t e;
            logic [31:0] act;
            e = q.pop_front();
            if (e.kind == 0) act = memData;
            else             act = {24'h0, u_dut.data[e.idx]};
            total++;
            if (act !== e.exp) begin
               bad++;
               $display("FAIL %s: got %08h expected %08h", e.name, act, e.exp);
            end
         end
      end
   end

   task automatic push_word(input logic [31:0] exp, input string name);
      exp_t e;
      e.kind = 0; e.idx = 0; e.exp = exp; e.name = name;
      q.push_back(e);
   endtask

   task automatic push_byte(input int idx, input logic [7:0] exp, input string name);
      exp_t e;
      e.kind = 1; e.idx = idx; e.exp = {24'h0, exp}; e.name = name;
      q.push_back(e);
   endtask

   task automatic strobe();
      ->chk_ev;
      #2;
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] val);
      @(negedge clk);
      address   = addr;
      writeData = val;
      memWrite  = 1'b1;
      memRead   = 1'b0;
      @(negedge clk);
      memWrite  = 1'b0;
   endtask

   task automatic check_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
      @(negedge clk);
      address = addr;
      memRead = 1'b1;
      push_word(exp, name);
      strobe();
   endtask

   initial begin
      reset     = 1'b0;
      address   = 32'd0;
      writeData = 32'd0;
      memRead   = 1'b1;
      memWrite  = 1'b0;

      // Reset state and a write attempted while reset is held
      @(negedge clk);
      address = 32'd10; writeData = 32'hDEADBEEF; memWrite = 1'b1;
      push_word(32'h0, "rst_read_zero");
      push_byte(5, 8'h00, "rst_byte5");
      strobe();
      @(negedge clk);
      memWrite = 1'b0;
      reset    = 1'b1;
      push_byte(10, 8'h00, "rst_write_ignored");
      strobe();

      // Small store, little-endian byte layout
      do_write(32'd3, 32'd200);
      check_read(32'd3, 32'd200, "rd3");
      push_byte(3, 8'hC8, "b3");
      push_byte(4, 8'h00, "b4");
      push_byte(6, 8'h00, "b6");
      strobe();

      do_write(32'd20, 32'h000B72DD);
      check_read(32'd20, 32'h000B72DD, "rd20");
      @(negedge clk);
      memRead = 1'b0;
      push_word(32'h0, "rd20_disabled");
      strobe();
      check_read(32'h0000_0114, 32'h000B72DD, "upper_addr_ignored");

      // Unaligned access
      do_write(32'd30, 32'hFFFFFFFE);
      push_byte(30, 8'hFE, "b30");
      push_byte(33, 8'hFF, "b33");
      strobe();
      check_read(32'd30, 32'hFFFFFFFE, "rd30");
      check_read(32'd33, 32'h000000FF, "rd33_unaligned");

      // Wrap at the top of memory
      do_write(DEPTH - 2, 32'h11223344);
      push_byte(DEPTH - 2, 8'h44, "b_top2");
      push_byte(DEPTH - 1, 8'h33, "b_top1");
      push_byte(0, 8'h22, "b0_wrap");
      push_byte(1, 8'h11, "b1_wrap");
      strobe();
      check_read(DEPTH - 2, 32'h11223344, "rd_wrap");
      check_read(DEPTH - 1, 32'h00112233, "rd_top_wrap");
      check_read(32'd0, 32'hC8001122, "rd0_mixed");

      // memWrite low leaves memory untouched across an edge
      @(negedge clk);
      address = 32'd20; writeData = 32'h55555555; memWrite = 1'b0; memRead = 1'b1;
      @(negedge clk);
      push_word(32'h000B72DD, "no_write_kept");
      strobe();

      // Read-during-write: old data before the edge, new data after
      @(negedge clk);
      address = 32'd40; writeData = 32'h12345678; memWrite = 1'b1; memRead = 1'b1;
      push_word(32'h0, "rdw_before");
      strobe();
      @(negedge clk);
      memWrite = 1'b0;
      push_word(32'h12345678, "rdw_after");
      strobe();

      // Asynchronous reset between edges clears memory at once
      do_write(32'd8, 32'hA5A5A5A5);
      check_read(32'd8, 32'hA5A5A5A5, "rd8_before_rst");
      @(negedge clk);
      #1 reset = 1'b0;
      push_word(32'h0, "rd8_in_rst");
      push_byte(8, 8'h00, "b8_cleared");
      push_byte(40, 8'h00, "b40_cleared");
      strobe();
      reset = 1'b1;
      push_word(32'h0, "rd8_after_rst_no_edge");
      strobe();

      // Reset held across an edge discards an in-progress write; next write works
      @(negedge clk);
      address = 32'd50; writeData = 32'hDEADBEEF; memWrite = 1'b1; reset = 1'b0;
      @(negedge clk);
      memWrite = 1'b0; reset = 1'b1;
      push_byte(50, 8'h00, "rst_discard_write");
      strobe();
      do_write(32'd50, 32'hCAFEBABE);
      check_read(32'd50, 32'hCAFEBABE, "first_write_after_rst");

      @(negedge clk);
      #2;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
